mem_allocator: RTL and testbench

Arbiter and sequencer for the single byte-wide RAM port. Shares it between instruction fetch (4-byte reads), LSBuffer loads (1/2/4-byte reads) and LSBuffer committed stores (1/2/4-byte writes), converting each granted request into a byte-serial RAM sequence and returning a one-cycle completion pulse. Sits between the fetch/LSBuffer stage and the top-level RAM/IO pins.

---
 rtl/mem_allocator.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mem_allocator.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_allocator.sv
// mem_allocator: arbiter and byte-serial sequencer for the shared byte-wide RAM port.
//
// Serves three requesters over one 8-bit RAM port:
//   - instruction fetch: 4-byte reads
//   - LSBuffer loads:    1/2/4-byte reads, zero-extended
//   - LSBuffer stores:   1/2/4-byte writes
// Fixed priority in IDLE is store > load > fetch. A store to the IO region is
// held off while the IO buffer is full.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable; low freezes state)
//   if_to_alloc_en_in / if_a_in                 fetch request and address
//   alloc_to_if_gr_out / alloc_to_if_en_out     fetch grant / done pulses
//   if_d_out                                    fetched word, little-endian
//   lsb_to_alloc_r_en_in / lsb_r_offset_in / lsb_r_a_in   load request (offset = bytes-1)
//   alloc_to_lsb_r_gr_out / alloc_to_lsb_r_en_out         load grant / done pulses
//   lsb_d_out                                   load data, zero-extended
//   lsb_to_alloc_w_en_in / lsb_w_offset_in / lsb_w_a_in / lsb_d_in   store request
//   alloc_to_lsb_w_gr_out / alloc_to_lsb_w_en_out         store grant / done pulses
//   clear_branch_in      misprediction flush (aborts reads, not writes)
//   io_buffer_full_in    back-pressure for IO-region stores
//   mem_din / mem_dout / mem_a / mem_wr         RAM port (mem_wr masked by rdy_in)

module mem_allocator #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,

    input  logic                  if_to_alloc_en_in,
    input  logic [ADDR_WIDTH-1:0] if_a_in,
    output logic                  alloc_to_if_gr_out,
    output logic                  alloc_to_if_en_out,
    output logic [31:0]           if_d_out,

    input  logic                  lsb_to_alloc_r_en_in,
    input  logic [1:0]            lsb_r_offset_in,
    input  logic [ADDR_WIDTH-1:0] lsb_r_a_in,
    output logic                  alloc_to_lsb_r_gr_out,
    output logic                  alloc_to_lsb_r_en_out,
    output logic [31:0]           lsb_d_out,

    input  logic                  lsb_to_alloc_w_en_in,
    input  logic [1:0]            lsb_w_offset_in,
    input  logic [ADDR_WIDTH-1:0] lsb_w_a_in,
    input  logic [31:0]           lsb_d_in,
    output logic                  alloc_to_lsb_w_gr_out,
    output logic                  alloc_to_lsb_w_en_out,

    input  logic                  clear_branch_in,
    input  logic                  io_buffer_full_in,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Sequencer state
    state_e                state_q, state_d;
    logic [2:0]            step_q, step_d;     // active edges elapsed since grant, minus one
    logic [1:0]            off_q, off_d;       // transfer length minus one
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  own_if_q, own_if_d; // read owner: 1 = fetch, 0 = load
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    // Registered outputs
    logic                  if_gr_q, if_gr_d;
    logic                  if_en_q, if_en_d;
    logic                  r_gr_q, r_gr_d;
    logic                  r_en_q, r_en_d;
    logic                  w_gr_q, w_gr_d;
    logic                  w_en_q, w_en_d;
    logic [DW-1:0]         if_d_q, if_d_d;
    logic [DW-1:0]         lsb_d_q, lsb_d_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  wr_q, wr_d;

    // Byte bookkeeping derived from the step counter
    logic [2:0] k_c;          // index of the edge being computed (1 = first after grant)
    logic       issue_c;      // another address still to be driven
    logic [1:0] iss_idx_c;    // byte index to drive on this edge
    logic [1:0] cap_idx_c;    // byte index arriving on mem_din this edge
    logic [4:0] cap_sh_c;
    logic [4:0] iss_sh_c;
    logic       store_ok_c;

    always_comb begin
        k_c        = step_q + 3'd1;
        issue_c    = (k_c <= 3'(off_q));
        iss_idx_c  = 2'(k_c);
        cap_idx_c  = 2'(k_c - 3'd2);
        cap_sh_c   = {cap_idx_c, 3'b000};
        iss_sh_c   = {iss_idx_c, 3'b000};
        // IO stores wait while the IO buffer cannot accept them
        store_ok_c = lsb_to_alloc_w_en_in &&
                     !((lsb_w_a_in[17:16] == IO_SEL) && io_buffer_full_in);
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        off_d      = off_q;
        base_d     = base_q;
        own_if_d   = own_if_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if_gr_d    = if_gr_q;
        if_en_d    = if_en_q;
        r_gr_d     = r_gr_q;
        r_en_d     = r_en_q;
        w_gr_d     = w_gr_q;
        w_en_d     = w_en_q;
        if_d_d     = if_d_q;
        lsb_d_d    = lsb_d_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;

        if (rdy_in) begin
            // Grant and done strobes are single-cycle pulses
            if_gr_d = 1'b0;
            if_en_d = 1'b0;
            r_gr_d  = 1'b0;
            r_en_d  = 1'b0;
            w_gr_d  = 1'b0;
            w_en_d  = 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    step_d  = 3'd0;
                    mem_a_d = '0;
                    wr_d    = 1'b0;
                    if (store_ok_c) begin
                        // Store is already committed, so a flush does not block it
                        state_d    = ST_WRITE;
                        base_d     = lsb_w_a_in;
                        off_d      = lsb_w_offset_in;
                        wdata_d    = lsb_d_in;
                        w_gr_d     = 1'b1;
                        mem_a_d    = lsb_w_a_in;
                        mem_dout_d = lsb_d_in[7:0];
                        wr_d       = 1'b1;
                    end else if (lsb_to_alloc_r_en_in && !clear_branch_in) begin
                        state_d  = ST_READ;
                        base_d   = lsb_r_a_in;
                        off_d    = lsb_r_offset_in;
                        own_if_d = 1'b0;
                        rdata_d  = '0;
                        r_gr_d   = 1'b1;
                        mem_a_d  = lsb_r_a_in;
                    end else if (if_to_alloc_en_in && !clear_branch_in) begin
                        state_d  = ST_READ;
                        base_d   = if_a_in;
                        off_d    = 2'd3;
                        own_if_d = 1'b1;
                        rdata_d  = '0;
                        if_gr_d  = 1'b1;
                        mem_a_d  = if_a_in;
                    end
                end

                ST_READ: begin
                    step_d = k_c;
                    if (clear_branch_in) begin
                        // Speculative read squashed: no completion reported
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                        mem_a_d = '0;
                    end else begin
                        if (issue_c) begin
                            mem_a_d = base_q + ADDR_WIDTH'(k_c);
                        end
                        // RAM returns byte i two edges after its address is registered
                        if (k_c >= 3'd2) begin
                            rdata_d = rdata_q | (DW'(mem_din) << cap_sh_c);
                        end
                        if (k_c == 3'(off_q) + 3'd2) begin
                            state_d = ST_IDLE;
                            step_d  = 3'd0;
                            mem_a_d = '0;
                            if (own_if_q) begin
                                if_en_d = 1'b1;
                                if_d_d  = rdata_d;
                            end else begin
                                r_en_d  = 1'b1;
                                lsb_d_d = rdata_d;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    step_d = k_c;
                    if (issue_c) begin
                        mem_a_d    = base_q + ADDR_WIDTH'(k_c);
                        mem_dout_d = 8'(wdata_q >> iss_sh_c);
                        wr_d       = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        step_d  = 3'd0;
                        mem_a_d = '0;
                        wr_d    = 1'b0;
                        w_en_d  = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    step_d  = 3'd0;
                    mem_a_d = '0;
                    wr_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            off_q      <= '0;
            base_q     <= '0;
            own_if_q   <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            if_gr_q    <= 1'b0;
            if_en_q    <= 1'b0;
            r_gr_q     <= 1'b0;
            r_en_q     <= 1'b0;
            w_gr_q     <= 1'b0;
            w_en_q     <= 1'b0;
            if_d_q     <= '0;
            lsb_d_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            off_q      <= off_d;
            base_q     <= base_d;
            own_if_q   <= own_if_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            if_gr_q    <= if_gr_d;
            if_en_q    <= if_en_d;
            r_gr_q     <= r_gr_d;
            r_en_q     <= r_en_d;
            w_gr_q     <= w_gr_d;
            w_en_q     <= w_en_d;
            if_d_q     <= if_d_d;
            lsb_d_q    <= lsb_d_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
        end
    end

    assign alloc_to_if_gr_out    = if_gr_q;
    assign alloc_to_if_en_out    = if_en_q;
    assign if_d_out              = if_d_q;
    assign alloc_to_lsb_r_gr_out = r_gr_q;
    assign alloc_to_lsb_r_en_out = r_en_q;
    assign lsb_d_out             = lsb_d_q;
    assign alloc_to_lsb_w_gr_out = w_gr_q;
    assign alloc_to_lsb_w_en_out = w_en_q;
    assign mem_a                 = mem_a_q;
    assign mem_dout              = mem_dout_q;
    // A frozen pipeline must not repeat a write strobe
    assign mem_wr                = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_allocator.sv
// Bench for mem_allocator: directed scenarios, a transaction-level reference
// model compared every cycle, and literal expectations for key results.

module tb_mem_allocator;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_in, rdy_in;
    logic          if_en, if_gr, if_done;
    logic [AW-1:0] if_a;
    logic [31:0]   if_d;
    logic          r_en, r_gr, r_done;
    logic [1:0]    r_off;
    logic [AW-1:0] r_a;
    logic [31:0]   lsb_d;
    logic          w_en, w_gr, w_done;
    logic [1:0]    w_off;
    logic [AW-1:0] w_a;
    logic [31:0]   w_d;
    logic          clear, io_full;
    logic [7:0]    mem_din = 8'h00;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;

    always #5 clk = ~clk;

    mem_allocator #(.ADDR_WIDTH(AW), .IO_SEL(2'b11)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_to_alloc_en_in(if_en), .if_a_in(if_a),
        .alloc_to_if_gr_out(if_gr), .alloc_to_if_en_out(if_done), .if_d_out(if_d),
        .lsb_to_alloc_r_en_in(r_en), .lsb_r_offset_in(r_off), .lsb_r_a_in(r_a),
        .alloc_to_lsb_r_gr_out(r_gr), .alloc_to_lsb_r_en_out(r_done), .lsb_d_out(lsb_d),
        .lsb_to_alloc_w_en_in(w_en), .lsb_w_offset_in(w_off), .lsb_w_a_in(w_a),
        .lsb_d_in(w_d),
        .alloc_to_lsb_w_gr_out(w_gr), .alloc_to_lsb_w_en_out(w_done),
        .clear_branch_in(clear), .io_buffer_full_in(io_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM: synchronous, paused together with the rest of the core when rdy is low
    logic [7:0]  ram  [0:262143];
    logic [7:0]  gold [0:262143];
    logic [39:0] wlog [$];

    function automatic int unsigned ix(input logic [31:0] a);
        return {14'd0, a[17:0]};
    endfunction

    always @(posedge clk) begin
        if (rdy_in) begin
            if (mem_wr) begin
                ram[ix(mem_a)] <= mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
            mem_din <= ram[ix(mem_a)];
        end
    end

    function automatic logic [39:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return 40'h0;
    endfunction

    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int n_r_done = 0;
    int n_w_done = 0;
    always @(posedge clk) begin
        #2;
        if (r_done === 1'b1) n_r_done++;
        if (w_done === 1'b1) n_w_done++;
    end

    // Transaction-level reference model
    int          m_kind = 0;       // 0 idle, 1 read, 2 write
    bit          m_valid = 1'b0;
    logic        m_own_if;
    logic [31:0] m_a, m_wd;
    int          m_n, m_e;
    logic        e_if_gr, e_if_en, e_r_gr, e_r_en, e_w_gr, e_w_en, e_wr;
    logic [31:0] e_if_d, e_lsb_d, e_mem_a;
    logic [7:0]  e_dout;

    task automatic put_wbyte();
        e_mem_a = m_a + 32'(m_e);
        e_dout  = m_wd[8*m_e +: 8];
        e_wr    = 1'b1;
        gold[ix(e_mem_a)] = e_dout;
    endtask

    function automatic logic [31:0] read_word(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = gold[ix(a + 32'(i))];
        return v;
    endfunction

    task automatic model_step();
        if (rst_in) begin
            m_kind = 0; m_valid = 1'b1;
            e_if_gr = 0; e_if_en = 0; e_r_gr = 0; e_r_en = 0; e_w_gr = 0; e_w_en = 0;
            e_wr = 0; e_if_d = 0; e_lsb_d = 0; e_mem_a = 0; e_dout = 0;
        end else if (rdy_in && m_valid) begin
            e_if_gr = 0; e_if_en = 0; e_r_gr = 0; e_r_en = 0; e_w_gr = 0; e_w_en = 0;
            if (m_kind == 0) begin
                if (w_en && !(w_a[17:16] == 2'b11 && io_full)) begin
                    m_kind = 2; m_a = w_a; m_n = int'(w_off) + 1; m_wd = w_d; m_e = 0;
                    e_w_gr = 1; put_wbyte();
                end else if (r_en && !clear) begin
                    m_kind = 1; m_own_if = 0; m_a = r_a; m_n = int'(r_off) + 1; m_e = 0;
                    e_r_gr = 1; e_mem_a = m_a;
                end else if (if_en && !clear) begin
                    m_kind = 1; m_own_if = 1; m_a = if_a; m_n = 4; m_e = 0;
                    e_if_gr = 1; e_mem_a = m_a;
                end
            end else if (m_kind == 1) begin
                m_e++;
                if (clear) begin
                    m_kind = 0; e_mem_a = 0;
                end else if (m_e == m_n + 1) begin
                    m_kind = 0; e_mem_a = 0;
                    if (m_own_if) begin e_if_en = 1; e_if_d = read_word(m_a, m_n); end
                    else begin e_r_en = 1; e_lsb_d = read_word(m_a, m_n); end
                end else if (m_e < m_n) begin
                    e_mem_a = m_a + 32'(m_e);
                end
            end else begin
                m_e++;
                if (m_e == m_n) begin
                    m_kind = 0; e_wr = 0; e_mem_a = 0; e_w_en = 1;
                end else begin
                    put_wbyte();
                end
            end
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        if (m_valid) begin
            chk("m_if_gr",  64'(if_gr),   64'(e_if_gr));
            chk("m_if_en",  64'(if_done), 64'(e_if_en));
            chk("m_r_gr",   64'(r_gr),    64'(e_r_gr));
            chk("m_r_en",   64'(r_done),  64'(e_r_en));
            chk("m_w_gr",   64'(w_gr),    64'(e_w_gr));
            chk("m_w_en",   64'(w_done),  64'(e_w_en));
            chk("m_if_d",   64'(if_d),    64'(e_if_d));
            chk("m_lsb_d",  64'(lsb_d),   64'(e_lsb_d));
            chk("m_mem_a",  64'(mem_a),   64'(e_mem_a));
            chk("m_mem_wr", 64'(mem_wr),  64'(e_wr & rdy_in));
            if (e_wr) chk("m_mem_dout", 64'(mem_dout), 64'(e_dout));
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0: return if_gr;
            1: return if_done;
            2: return r_gr;
            3: return r_done;
            4: return w_gr;
            default: return w_done;
        endcase
    endfunction

    // Bounded wait, sampled on the falling edge
    task automatic wait_for(input int s, input string name);
        int c = 0;
        while (sig(s) !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk(name, 64'(sig(s)), 64'd1);
    endtask

    task automatic set_byte(input logic [31:0] a, input logic [7:0] b);
        ram[ix(a)]  = b;
        gold[ix(a)] = b;
    endtask

    int unsigned t0;
    int          snap;

    initial begin
        rst_in = 1; rdy_in = 1; if_en = 0; if_a = 0; r_en = 0; r_off = 0; r_a = 0;
        w_en = 0; w_off = 0; w_a = 0; w_d = 0; clear = 0; io_full = 0;
        for (int i = 0; i < 262144; i++) begin
            ram[i]  = 8'(i * 7 + 3);
            gold[i] = 8'(i * 7 + 3);
        end
        set_byte(32'h1000, 8'h11); set_byte(32'h1001, 8'h22);
        set_byte(32'h1002, 8'h33); set_byte(32'h1003, 8'h44);
        set_byte(32'h1004, 8'h55); set_byte(32'h1005, 8'h66);
        set_byte(32'h1006, 8'h77); set_byte(32'h1007, 8'h88);
        set_byte(32'h2003, 8'h80);

        repeat (3) @(negedge clk);
        rst_in = 0;
        chk("rst_mem_a",  64'(mem_a),  64'h0);
        chk("rst_mem_wr", 64'(mem_wr), 64'h0);
        chk("rst_if_d",   64'(if_d),   64'h0);
        chk("rst_lsb_d",  64'(lsb_d),  64'h0);
        chk("rst_grants", 64'({if_gr, r_gr, w_gr}), 64'h0);
        chk("rst_dones",  64'({if_done, r_done, w_done}), 64'h0);

        // Fetch LW at 0x1000
        if_en = 1; if_a = 32'h1000;
        wait_for(0, "lw_gr");
        t0 = ncyc; if_en = 0;
        chk("lw_first_addr", 64'(mem_a), 64'h1000);
        wait_for(1, "lw_done");
        chk("lw_latency", 64'(ncyc - t0), 64'd5);
        chk("lw_data", 64'(if_d), 64'h44332211);

        // Load LB beats a simultaneous fetch
        r_en = 1; r_off = 2'd0; r_a = 32'h2003;
        if_en = 1; if_a = 32'h1004;
        wait_for(2, "lb_gr");
        chk("lb_no_if_gr", 64'(if_gr), 64'h0);
        r_en = 0;
        wait_for(3, "lb_done");
        chk("lb_data", 64'(lsb_d), 64'h80);
        t0 = ncyc;
        wait_for(0, "if2_gr");
        chk("if2_next_edge", 64'(ncyc - t0), 64'd1);
        if_en = 0;
        wait_for(1, "if2_done");
        chk("if2_data", 64'(if_d), 64'h88776655);

        // Store SH 0xBEEF to 0x3000
        wlog.delete();
        w_en = 1; w_off = 2'd1; w_a = 32'h3000; w_d = 32'h0000BEEF;
        wait_for(4, "sh_gr");
        w_en = 0;
        wait_for(5, "sh_done");
        repeat (3) @(negedge clk);
        chk("sh_nwrites", 64'(wlog.size()), 64'd2);
        chk("sh_w0", 64'(wl(0)), 64'({32'h3000, 8'hEF}));
        chk("sh_w1", 64'(wl(1)), 64'({32'h3001, 8'hBE}));

        // IO store blocked by full buffer; fetch served meanwhile
        wlog.delete();
        io_full = 1;
        w_en = 1; w_off = 2'd0; w_a = 32'h0003_0000; w_d = 32'h0000005A;
        if_en = 1; if_a = 32'h1000;
        wait_for(0, "io_if_gr");
        chk("io_no_w_gr", 64'(w_gr), 64'h0);
        if_en = 0;
        repeat (4) @(negedge clk);
        chk("io_no_write_full", 64'(wlog.size()), 64'd0);
        io_full = 0; t0 = ncyc;
        wait_for(4, "io_w_gr");
        chk("io_gr_after_drop", 64'(ncyc > t0), 64'd1);
        w_en = 0;
        wait_for(5, "io_done");
        repeat (2) @(negedge clk);
        chk("io_nwrites", 64'(wlog.size()), 64'd1);
        chk("io_w0", 64'(wl(0)), 64'({32'h0003_0000, 8'h5A}));

        // LW load flushed after two bytes
        r_en = 1; r_off = 2'd3; r_a = 32'h1000;
        wait_for(2, "clr_gr");
        r_en = 0; snap = n_r_done;
        repeat (3) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("clr_mem_a", 64'(mem_a), 64'h0);
        chk("clr_no_done", 64'(r_done), 64'h0);
        repeat (6) @(negedge clk);
        chk("clr_done_cnt", 64'(n_r_done - snap), 64'd0);
        chk("clr_lsb_d_kept", 64'(lsb_d), 64'h80);

        // Store survives a flush
        wlog.delete();
        w_en = 1; w_off = 2'd3; w_a = 32'h3100; w_d = 32'hCAFEF00D;
        wait_for(4, "sw_clr_gr");
        w_en = 0;
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        wait_for(5, "sw_clr_done");
        repeat (2) @(negedge clk);
        chk("sw_clr_nwrites", 64'(wlog.size()), 64'd4);
        chk("sw_clr_w0", 64'(wl(0)), 64'({32'h3100, 8'h0D}));
        chk("sw_clr_w3", 64'(wl(3)), 64'({32'h3103, 8'hCA}));

        // rdy low for 3 cycles in the middle of a fetch
        if_en = 1; if_a = 32'h1000;
        wait_for(0, "rdy_gr");
        if_en = 0;
        repeat (2) @(negedge clk);
        rdy_in = 0;
        repeat (3) @(negedge clk);
        rdy_in = 1;
        wait_for(1, "rdy_done");
        chk("rdy_data", 64'(if_d), 64'h44332211);

        // rdy low in the middle of a store: strobe masked, no duplicated bytes
        wlog.delete();
        w_en = 1; w_off = 2'd3; w_a = 32'h3200; w_d = 32'h11223344;
        wait_for(4, "rdyw_gr");
        w_en = 0;
        @(negedge clk);
        rdy_in = 0;
        @(posedge clk); #1;
        chk("rdyw_masked", 64'(mem_wr), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1;
        wait_for(5, "rdyw_done");
        repeat (2) @(negedge clk);
        chk("rdyw_nwrites", 64'(wlog.size()), 64'd4);
        chk("rdyw_w1", 64'(wl(1)), 64'({32'h3201, 8'h33}));

        // Reset in the middle of a store
        w_en = 1; w_off = 2'd3; w_a = 32'h3300; w_d = 32'hA5A5A5A5;
        wait_for(4, "rstw_gr");
        w_en = 0; snap = n_w_done;
        @(negedge clk);
        rst_in = 1;
        @(negedge clk);
        rst_in = 0;
        chk("rstw_mem_wr", 64'(mem_wr), 64'h0);
        chk("rstw_mem_a",  64'(mem_a),  64'h0);
        chk("rstw_if_d",   64'(if_d),   64'h0);
        chk("rstw_lsb_d",  64'(lsb_d),  64'h0);
        chk("rstw_outs",   64'({if_gr, r_gr, w_gr, if_done, r_done, w_done}), 64'h0);
        repeat (6) @(negedge clk);
        chk("rstw_no_done", 64'(n_w_done - snap), 64'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
